// File: rtl/flame_pkg.sv
// Shared types and constants for the flame scheduler and its explosion slots.
package flame_pkg;

    localparam int NUM_SLOTS    = 4;
    localparam int GRID_W       = 15;
    localparam int GRID_H       = 13;
    localparam int FLAME_FRAMES = 60;
    localparam int RANGE_W      = 3;
    localparam int TIMER_W      = 7;
    localparam int SPRITE_DIM   = 28;
    localparam int PIX_W        = $clog2(SPRITE_DIM);

    typedef logic [3:0]         coord_t;
    typedef logic [RANGE_W-1:0] range_t;
    typedef logic [TIMER_W-1:0] timer_t;
    typedef logic [PIX_W-1:0]   pix_t;

    typedef enum logic {
        IDLE = 1'b0,
        BURN = 1'b1
    } slot_state_e;

    typedef struct packed {
        slot_state_e state;
        coord_t      x;
        coord_t      y;
        range_t      range;
        timer_t      timer;
    } slot_t;

    // Distance between two cell coordinates, widened so the subtraction cannot wrap.
    function automatic logic [4:0] abs_diff(input coord_t a, input coord_t b);
        logic [4:0] wa;
        logic [4:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa >= wb) ? (wa - wb) : (wb - wa);
    endfunction

endpackage

// File: rtl/flame_slot.sv
// One explosion slot: burn timer, lifecycle FSM and cross-shaped coverage test.
module flame_slot
    import flame_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   frame_tick,
    input  logic   alloc,
    input  coord_t det_x,
    input  coord_t det_y,
    input  range_t det_range,
    input  coord_t q_x,
    input  coord_t q_y,
    output logic   idle,
    output logic   burn_next,
    output logic   covered
);

    slot_t cur;
    slot_t nxt;

    // Slot register; reset returns the slot to IDLE with a cleared timer.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic: a fresh allocation ignores the frame tick, a tick at timer 1 frees the slot.
    always_comb begin
        nxt = cur;
        case (cur.state)
            IDLE: begin
                if (alloc) begin
                    nxt.state = BURN;
                    nxt.x     = det_x;
                    nxt.y     = det_y;
                    nxt.range = det_range;
                    nxt.timer = timer_t'(FLAME_FRAMES);
                end
            end
            BURN: begin
                if (frame_tick) begin
                    if (cur.timer == timer_t'(1)) begin
                        nxt.state = IDLE;
                        nxt.timer = '0;
                    end else begin
                        nxt.timer = cur.timer - timer_t'(1);
                    end
                end
            end
            default: nxt = cur;
        endcase
    end

    logic [4:0] dx;
    logic [4:0] dy;
    logic [4:0] reach;

    // Coverage is a plus shape around the bomb cell; the grid edge clips the arms for free.
    always_comb begin
        dx      = abs_diff(q_x, cur.x);
        dy      = abs_diff(q_y, cur.y);
        reach   = 5'(cur.range);
        covered = (cur.state == BURN) &&
                  (((q_y == cur.y) && (dx <= reach)) ||
                   ((q_x == cur.x) && (dy <= reach)));
    end

    assign idle      = (cur.state == IDLE);
    assign burn_next = (nxt.state == BURN);

endmodule

// File: rtl/flame_scheduler.sv
// Explosion tracker: slot allocator, burning-slot count and per-pixel flame query.
module flame_scheduler
    import flame_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               det_valid,
    output logic               det_ready,
    input  logic [3:0]         det_x,
    input  logic [3:0]         det_y,
    input  logic [RANGE_W-1:0] det_range,
    input  logic               q_valid,
    input  logic [3:0]         q_x,
    input  logic [3:0]         q_y,
    input  logic [4:0]         q_px,
    input  logic [4:0]         q_py,
    output logic               r_valid,
    output logic               r_hit,
    output logic [4:0]         r_row,
    output logic [4:0]         r_col,
    output logic [2:0]         active_cnt
);

    localparam coord_t GRID_W_C = coord_t'(GRID_W);
    localparam coord_t GRID_H_C = coord_t'(GRID_H);

    logic [NUM_SLOTS-1:0] idle;
    logic [NUM_SLOTS-1:0] burn_next;
    logic [NUM_SLOTS-1:0] covered;
    logic [NUM_SLOTS-1:0] alloc;
    logic                 found;
    logic [2:0]           cnt_next;
    logic                 hit_now;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        flame_slot u_slot (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .frame_tick (frame_tick),
            .alloc      (alloc[i]),
            .det_x      (det_x),
            .det_y      (det_y),
            .det_range  (det_range),
            .q_x        (q_x),
            .q_y        (q_y),
            .idle       (idle[i]),
            .burn_next  (burn_next[i]),
            .covered    (covered[i])
        );
    end

    // Ready reflects registered slot state only, so a slot expiring this cycle is not yet free.
    assign det_ready = |idle;

    // Priority allocator: lowest idle slot wins; off-grid requests are accepted but consume nothing.
    always_comb begin
        alloc = '0;
        found = 1'b0;
        if (det_valid && det_ready && (det_x < GRID_W_C) && (det_y < GRID_H_C)) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (idle[i] && !found) begin
                    alloc[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    // Count the slots that will be burning after this edge.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_next = cnt_next + {2'b00, burn_next[i]};
        end
    end

    assign hit_now = q_valid && (|covered);

    // Burning-slot count register, updated alongside the slot states.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_cnt <= '0;
        end else begin
            active_cnt <= cnt_next;
        end
    end

    // One-cycle query result register; sprite coordinates are zeroed on a miss.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_valid <= q_valid;
            r_hit   <= hit_now;
            r_row   <= hit_now ? q_py : 5'd0;
            r_col   <= hit_now ? q_px : 5'd0;
        end
    end

endmodule

// File: tb/tb_flame_scheduler.sv
// Self-checking bench for flame_scheduler: directed scenarios plus a per-cycle reference model.
module tb_flame_scheduler;

    logic       Clk;
    logic       Reset_n;
    logic       frame_tick;
    logic       det_valid;
    logic       det_ready;
    logic [3:0] det_x;
    logic [3:0] det_y;
    logic [2:0] det_range;
    logic       q_valid;
    logic [3:0] q_x;
    logic [3:0] q_y;
    logic [4:0] q_px;
    logic [4:0] q_py;
    logic       r_valid;
    logic       r_hit;
    logic [4:0] r_row;
    logic [4:0] r_col;
    logic [2:0] active_cnt;

    int errors = 0;
    int checks = 0;

    flame_scheduler dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .det_valid  (det_valid),
        .det_ready  (det_ready),
        .det_x      (det_x),
        .det_y      (det_y),
        .det_range  (det_range),
        .q_valid    (q_valid),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_px       (q_px),
        .q_py       (q_py),
        .r_valid    (r_valid),
        .r_hit      (r_hit),
        .r_row      (r_row),
        .r_col      (r_col),
        .active_cnt (active_cnt)
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: each explosion is a record with frames left; 0 frames left means free.
    int  m_left [4];
    int  m_x    [4];
    int  m_y    [4];
    int  m_r    [4];
    int  e_valid, e_hit, e_row, e_col, e_active, e_ready;

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Advance the model on each edge using the inputs that were presented before it.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < 4; s++) begin
                m_left[s] = 0; m_x[s] = 0; m_y[s] = 0; m_r[s] = 0;
            end
            e_valid = 0; e_hit = 0; e_row = 0; e_col = 0; e_active = 0; e_ready = 1;
        end else begin
            int hit;
            int freeIdx;
            hit = 0;
            freeIdx = -1;
            for (int s = 0; s < 4; s++) begin
                if (m_left[s] > 0) begin
                    if ((q_y == m_y[s] && absInt(int'(q_x) - m_x[s]) <= m_r[s]) ||
                        (q_x == m_x[s] && absInt(int'(q_y) - m_y[s]) <= m_r[s]))
                        hit = 1;
                end else if (freeIdx < 0) begin
                    freeIdx = s;
                end
            end
            e_valid = q_valid;
            e_hit   = q_valid && hit;
            e_row   = e_hit ? int'(q_py) : 0;
            e_col   = e_hit ? int'(q_px) : 0;
            if (frame_tick) begin
                for (int s = 0; s < 4; s++)
                    if (m_left[s] > 0) m_left[s]--;
            end
            if (det_valid && freeIdx >= 0 && det_x < 15 && det_y < 13) begin
                m_left[freeIdx] = 60;
                m_x[freeIdx]    = det_x;
                m_y[freeIdx]    = det_y;
                m_r[freeIdx]    = det_range;
            end
            e_active = 0;
            e_ready  = 0;
            for (int s = 0; s < 4; s++) begin
                if (m_left[s] > 0) e_active++;
                else e_ready = 1;
            end
        end
    end

    // Compare every output against the model shortly after each edge while out of reset.
    always @(posedge Clk) begin
        #1;
        if (Reset_n) begin
            checkOutput("model_r_valid", r_valid, e_valid);
            checkOutput("model_r_hit", r_hit, e_hit);
            checkOutput("model_r_row", r_row, e_row);
            checkOutput("model_r_col", r_col, e_col);
            checkOutput("model_active_cnt", active_cnt, e_active);
            checkOutput("model_det_ready", det_ready, e_ready);
        end
    end

    task automatic applyDet(input int x, input int y, input int r);
        int n;
        n = 0;
        @(negedge Clk);
        det_valid = 1'b1;
        det_x     = 4'(x);
        det_y     = 4'(y);
        det_range = 3'(r);
        while (!det_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL det_timeout: det_ready stayed 0, required 1");
        end
        @(negedge Clk);
        det_valid = 1'b0;
    endtask

    task automatic applyQuery(input int x, input int y, input int px, input int py,
                              input int expHit, input int expRow, input int expCol);
        @(negedge Clk);
        q_valid = 1'b1;
        q_x     = 4'(x);
        q_y     = 4'(y);
        q_px    = 5'(px);
        q_py    = 5'(py);
        @(negedge Clk);
        q_valid = 1'b0;
        checkOutput("query_r_valid", r_valid, 1);
        checkOutput("query_r_hit", r_hit, expHit);
        checkOutput("query_r_row", r_row, expRow);
        checkOutput("query_r_col", r_col, expCol);
    endtask

    task automatic pulseTicks(input int n);
        repeat (n) begin
            @(negedge Clk);
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0; det_valid = 1'b0;
        det_x = '0; det_y = '0; det_range = '0;
        q_valid = 1'b0; q_x = '0; q_y = '0; q_px = '0; q_py = '0;
        #12;
        checkOutput("reset_det_ready", det_ready, 1);
        checkOutput("reset_active_cnt", active_cnt, 0);
        checkOutput("reset_r_valid", r_valid, 0);
        checkOutput("reset_r_hit", r_hit, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Single explosion and its arm edges.
        applyDet(5, 5, 2);
        applyQuery(7, 5, 3, 4, 1, 4, 3);
        applyQuery(8, 5, 3, 4, 0, 0, 0);
        applyQuery(6, 6, 3, 4, 0, 0, 0);
        applyQuery(5, 3, 11, 27, 1, 27, 11);

        // Fill every slot, then hold a fifth request until a slot frees.
        applyDet(10, 1, 1);
        applyDet(0, 12, 3);
        applyDet(14, 0, 7);
        checkOutput("full_det_ready", det_ready, 0);
        checkOutput("full_active_cnt", active_cnt, 4);
        @(negedge Clk);
        det_valid = 1'b1; det_x = 4'd1; det_y = 4'd1; det_range = 3'd1;
        pulseTicks(59);
        checkOutput("held_det_ready", det_ready, 0);
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        checkOutput("expired_det_ready", det_ready, 1);
        checkOutput("expired_active_cnt", active_cnt, 0);
        @(negedge Clk);
        det_valid = 1'b0;
        checkOutput("fifth_active_cnt", active_cnt, 1);
        applyQuery(1, 2, 6, 8, 1, 8, 6);

        // Range 0 lifetime: exactly 60 ticks.
        pulseTicks(60);
        checkOutput("drained_active_cnt", active_cnt, 0);
        applyDet(2, 2, 0);
        pulseTicks(59);
        applyQuery(2, 2, 10, 20, 1, 20, 10);
        applyQuery(3, 2, 10, 20, 0, 0, 0);
        pulseTicks(1);
        applyQuery(2, 2, 10, 20, 0, 0, 0);
        checkOutput("lifetime_active_cnt", active_cnt, 0);

        // Accept coincident with a frame tick loads a full timer.
        @(negedge Clk);
        det_valid = 1'b1; det_x = 4'd6; det_y = 4'd7; det_range = 3'd1; frame_tick = 1'b1;
        @(negedge Clk);
        det_valid = 1'b0; frame_tick = 1'b0;
        checkOutput("coincident_active_cnt", active_cnt, 1);
        pulseTicks(59);
        applyQuery(6, 8, 1, 2, 1, 2, 1);
        pulseTicks(1);
        applyQuery(6, 8, 1, 2, 0, 0, 0);

        // Off-grid requests are swallowed without using a slot.
        applyDet(15, 3, 1);
        checkOutput("offgrid_x_active_cnt", active_cnt, 0);
        applyDet(3, 13, 1);
        checkOutput("offgrid_y_active_cnt", active_cnt, 0);
        checkOutput("offgrid_det_ready", det_ready, 1);

        // Duplicate cell takes two slots, then reset lands mid-burn with a query in flight.
        applyDet(4, 4, 1);
        applyDet(4, 4, 1);
        checkOutput("duplicate_active_cnt", active_cnt, 2);
        pulseTicks(3);
        @(negedge Clk);
        q_valid = 1'b1; q_x = 4'd4; q_y = 4'd5; q_px = 5'd7; q_py = 5'd9;
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_r_valid", r_valid, 0);
        checkOutput("async_r_hit", r_hit, 0);
        checkOutput("async_r_row", r_row, 0);
        checkOutput("async_r_col", r_col, 0);
        checkOutput("async_active_cnt", active_cnt, 0);
        checkOutput("async_det_ready", det_ready, 1);
        q_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checkOutput("post_reset_det_ready", det_ready, 1);
        checkOutput("post_reset_active_cnt", active_cnt, 0);
        applyQuery(4, 4, 7, 9, 0, 0, 0);

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
